rv32i_issue_stage: RTL
======================

Name: rv32i_issue_stage

Overview:
- Decode/operand-issue stage that feeds the integer ALU.
- Accepts fetched RV32I instruction words and decodes them into the ALU control fields: func7 (instr bit 30), funct3 and op.
- Reads operands from an internal 31x32 register file with writeback bypass, and blocks read-after-write hazards with a per-register pending scoreboard.
- Presents one registered issue packet to execute over a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- NREG, 32, architectural register count; x0 is hardwired to zero.

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_instr  in  32  instruction word
- in_pc  in  32  address of the instruction
- wb_en  in  1  writeback strobe
- wb_rd  in  5  writeback destination register
- wb_data  in  32  writeback value
- ex_valid  out  1  issue packet valid
- ex_ready  in  1  execute consumes the packet
- ex_in_a  out  32  ALU operand A
- ex_in_b  out  32  ALU operand B
- ex_func7  out  1  ALU func7 control (instr[30])
- ex_funct3  out  3  ALU funct3 control
- ex_op  out  7  ALU opcode control
- ex_imm  out  32  sign-extended immediate (branch offset for BRANCH)
- ex_pc  out  32  pc of the issued instruction
- ex_rd  out  5  destination register
- ex_rd_we  out  1  packet writes rd
- ex_illegal  out  1  unsupported or illegal encoding

Behaviour:
- Reset (synchronous, active-high):
  - ex_valid=0; all other ex_* outputs=0.
  - pending[31:0]=0; all registers=0.
  - in_ready=0 during the reset cycle.
  - Reset mid-handshake drops any held packet.
- Supported opcodes:
  - OP 0110011
  - OP-IMM 0010011
  - BRANCH 1100011
  - LUI 0110111
  - AUIPC 0010111
- Per-opcode operand and control mapping:
  - OP: a=rs1, b=rs2, imm=0.
  - OP-IMM: a=rs1, b=I-imm. For SRAI/SRLI, b[4:0]=shamt and func7 is taken from instr[30].
  - BRANCH: a=rs1, b=rs2, imm=B-imm, rd_we=0.
  - LUI: a=0, b=U-imm, funct3 forced to 000, func7 forced to 0.
  - AUIPC: a=in_pc, b=U-imm, funct3 forced to 000, func7 forced to 0.
  - All other cases: funct3=instr[14:12], func7=instr[30], op=instr[6:0].
- Illegal encodings:
  - Covered cases:
    - any other opcode
    - OP with funct7 other than 0x00/0x20
    - funct7 0x20 with funct3 not in {000,101}
    - OP-IMM funct3=001 with funct7≠0x00
    - OP-IMM funct3=101 with funct7 not in {0x00,0x20}
    - BRANCH funct3 in {010,011}
  - Required response: the packet still issues with ex_illegal=1 and rd_we=0, and pending is not set.
- rd_we: set to 1 for legal OP/OP-IMM/LUI/AUIPC with rd≠0; 0 otherwise.
- Hazard:
  - A source is "used" if rs≠0 and the opcode reads it: rs1 for OP/OP-IMM/BRANCH, rs2 for OP/BRANCH.
  - hazard=1 if a used source has pending[rs]=1, unless wb_en && wb_rd==rs in the same cycle (that write clears it and is bypassed).
- Handshake:
  - in_ready = ~reset & (~ex_valid | ex_ready) & ~(in_valid & hazard).
  - Accept = in_valid & in_ready. On accept, the packet registers and ex_valid=1 next cycle: 1-cycle latency, full throughput with no hazards.
  - If ex_ready=1 and there is no accept, ex_valid clears next cycle.
  - While ex_valid=1 and ex_ready=0, all ex_* outputs hold stable.
- Register file:
  - Write on wb_en when wb_rd≠0; writes to x0 are ignored.
  - Reads are combinational with same-cycle bypass: if wb_en and wb_rd==rs≠0, the operand is wb_data.
- Scoreboard:
  - wb_en with wb_rd≠0 clears pending[wb_rd].
  - An accept with rd_we sets pending[rd].
  - If both hit the same register in one cycle, set wins.
  - pending[0] is always 0.
- Immediates:
  - I = sext(instr[31:20])
  - B = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
  - U = {instr[31:12],12'b0}

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093) with ex_ready=1 -> ex_valid=1 one cycle later; a=0, b=5, op=0x13, funct3=0, rd=1, rd_we=1; pending[1]=1.
- After the previous step, issue ADD x2,x1,x1 with no writeback -> in_ready=0 while stalled. Then wb_en=1, wb_rd=1, wb_data=5 -> accepted that cycle with a=b=5 (bypass); pending[1]=0, pending[2]=1.
- SUB x3,x4,x5 (0x405201B3) with x4=9, x5=4 preloaded via writeback -> func7=1, funct3=000, op=0x33, a=9, b=4.
- Hold ex_ready=0 for 3 cycles after issue, with a second instruction at input -> ex_* outputs stable and in_ready=0. Set ex_ready=1 -> second packet issues the next cycle with no loss or duplication.
- BEQ x0,x0,-8 (0xFE000CE3) -> rd_we=0, imm=0xFFFFFFF8, a=b=0, no pending change. Opcode 0x0000007F -> ex_illegal=1, rd_we=0.
- Assert reset while ex_valid=1 and pending[1]=1 -> next cycle ex_valid=0, pending=0, and a read of x1 returns 0.

Source files
------------

// File: rtl/rv32i_issue_stage.sv
// RV32I decode/operand-issue stage: decodes ALU controls, reads the bypassed
// register file, blocks RAW hazards and holds one packet for execute.
module rv32i_issue_stage #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] ex_in_a,
   output logic [XLEN-1:0] ex_in_b,
   output logic            ex_func7,
   output logic [2:0]      ex_funct3,
   output logic [6:0]      ex_op,
   output logic [XLEN-1:0] ex_imm,
   output logic [XLEN-1:0] ex_pc,
   output logic [4:0]      ex_rd,
   output logic            ex_rd_we,
   output logic            ex_illegal
);

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_BR    = 7'b1100011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   logic [XLEN-1:0] regs_q [NREG-1:1];
   logic [NREG-1:0] pend_q, pend_d;

   logic            ex_valid_q;
   logic [XLEN-1:0] a_q, b_q, imm_q, pc_q;
   logic            f7_q, we_q, ill_q;
   logic [2:0]      f3_q;
   logic [6:0]      op_q;
   logic [4:0]      rd_q;

   logic [6:0] opc;
   logic [6:0] f7;
   logic [2:0] f3;
   logic [4:0] rs1, rs2, rd;

   assign opc = in_instr[6:0];
   assign rd  = in_instr[11:7];
   assign f3  = in_instr[14:12];
   assign rs1 = in_instr[19:15];
   assign rs2 = in_instr[24:20];
   assign f7  = in_instr[31:25];

   logic is_op, is_imm, is_br, is_lui, is_auipc;

   assign is_op    = (opc == OPC_OP);
   assign is_imm   = (opc == OPC_IMM);
   assign is_br    = (opc == OPC_BR);
   assign is_lui   = (opc == OPC_LUI);
   assign is_auipc = (opc == OPC_AUIPC);

   logic [XLEN-1:0] imm_i, imm_b, imm_u;

   assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_b = {{20{in_instr[31]}}, in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u = {in_instr[31:12], 12'b0};

   // Register reads see a same-cycle writeback
   logic [XLEN-1:0] op1, op2;

   always_comb begin
      op1 = '0;
      if (rs1 != 5'd0) begin
         if (wb_en && wb_rd == rs1) op1 = wb_data;
         else                       op1 = regs_q[rs1];
      end
   end

   always_comb begin
      op2 = '0;
      if (rs2 != 5'd0) begin
         if (wb_en && wb_rd == rs2) op2 = wb_data;
         else                       op2 = regs_q[rs2];
      end
   end

   logic            used1, used2, haz1, haz2, hazard, accept;

   assign used1 = (rs1 != 5'd0) & (is_op | is_imm | is_br);
   assign used2 = (rs2 != 5'd0) & (is_op | is_br);
   assign haz1  = used1 & pend_q[rs1] & ~(wb_en & (wb_rd == rs1));
   assign haz2  = used2 & pend_q[rs2] & ~(wb_en & (wb_rd == rs2));
   assign hazard = haz1 | haz2;

   assign in_ready = ~reset & (~ex_valid_q | ex_ready)
                   & ~(in_valid & hazard);
   assign accept   = in_valid & in_ready;

   logic [XLEN-1:0] d_a, d_b, d_imm;
   logic            d_f7, d_ill, d_we;
   logic [2:0]      d_f3;

   always_comb begin
      d_a   = '0;
      d_b   = '0;
      d_imm = '0;
      d_f7  = in_instr[30];
      d_f3  = f3;
      d_ill = 1'b0;
      unique case (1'b1)
         is_op: begin
            d_a   = op1;
            d_b   = op2;
            d_ill = ~((f7 == 7'h00) ||
                      (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
         end
         is_imm: begin
            d_a   = op1;
            d_b   = imm_i;
            d_imm = imm_i;
            d_ill = (f3 == 3'b001 && f7 != 7'h00) ||
                    (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
         end
         is_br: begin
            d_a   = op1;
            d_b   = op2;
            d_imm = imm_b;
            d_ill = (f3 == 3'b010) || (f3 == 3'b011);
         end
         is_lui: begin
            d_b   = imm_u;
            d_imm = imm_u;
            d_f3  = 3'b000;
            d_f7  = 1'b0;
         end
         is_auipc: begin
            d_a   = in_pc;
            d_b   = imm_u;
            d_imm = imm_u;
            d_f3  = 3'b000;
            d_f7  = 1'b0;
         end
         default: d_ill = 1'b1;
      endcase
   end

   assign d_we = ~d_ill & ~is_br & (rd != 5'd0);

   // A set from this cycle's accept overrides a same-register clear
   always_comb begin
      pend_d = pend_q;
      if (wb_en && wb_rd != 5'd0) pend_d[wb_rd] = 1'b0;
      if (accept && d_we)         pend_d[rd]    = 1'b1;
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q     <= '0;
         ex_valid_q <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         imm_q      <= '0;
         pc_q       <= '0;
         f7_q       <= 1'b0;
         f3_q       <= '0;
         op_q       <= '0;
         rd_q       <= '0;
         we_q       <= 1'b0;
         ill_q      <= 1'b0;
         for (int i = 1; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         pend_q <= pend_d;
         if (wb_en && wb_rd != 5'd0) regs_q[wb_rd] <= wb_data;
         if (accept) begin
            ex_valid_q <= 1'b1;
            a_q        <= d_a;
            b_q        <= d_b;
            imm_q      <= d_imm;
            pc_q       <= in_pc;
            f7_q       <= d_f7;
            f3_q       <= d_f3;
            op_q       <= opc;
            rd_q       <= rd;
            we_q       <= d_we;
            ill_q      <= d_ill;
         end else if (ex_ready) begin
            ex_valid_q <= 1'b0;
         end
      end
   end

   assign ex_valid   = ex_valid_q;
   assign ex_in_a    = a_q;
   assign ex_in_b    = b_q;
   assign ex_func7   = f7_q;
   assign ex_funct3  = f3_q;
   assign ex_op      = op_q;
   assign ex_imm     = imm_q;
   assign ex_pc      = pc_q;
   assign ex_rd      = rd_q;
   assign ex_rd_we   = we_q;
   assign ex_illegal = ill_q;

endmodule
